// File: rtl/collective_pkg.sv
// Shared definitions for the collective instruction generator:
// flit field positions, algorithm encodings, FSM states and
// communicator-entry field offsets.
package collective_pkg;

  // Input flit layout (73 bits); the output flit prepends the children count.
  localparam int FLIT_W      = 73;
  localparam int CHILD_W     = 3;
  localparam int OUT_W       = FLIT_W + CHILD_W;
  localparam int RANK_W      = 9;

  localparam int PAYLOAD_LSB = 0;
  localparam int PAYLOAD_W   = 32;
  localparam int OP_LSB      = 32;
  localparam int OP_W        = 4;
  localparam int ALG_LSB     = 36;
  localparam int ALG_W       = 2;
  localparam int TAG_LSB     = 38;
  localparam int TAG_W       = 8;
  localparam int CTX_LSB     = 46;
  localparam int CTX_W       = 8;
  localparam int SRC_LSB     = 54;
  localparam int DST_LSB     = 63;
  localparam int DST_W       = 9;
  localparam int VALID_BIT   = 72;
  localparam int CHILD_LSB   = 73;

  typedef enum logic [1:0] {
    ALG_UPTREE   = 2'd0,
    ALG_BCAST    = 2'd1,
    ALG_RING     = 2'd2,
    ALG_DOUBLING = 2'd3
  } alg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    SEND   = 2'd2
  } state_t;

  // Communicator entry: local_rank | children | lg_commsize | slot[mc-1..0]
  localparam int SLOT_W       = 9;
  localparam int LGC_W        = 4;
  localparam int CE_CHILD_W   = 3;
  localparam int LOCAL_RANK_W = 9;

  function automatic int lgc_lsb(input int mc);
    return SLOT_W * mc;
  endfunction

  function automatic int ce_child_lsb(input int mc);
    return SLOT_W * mc + LGC_W;
  endfunction

  function automatic int local_rank_lsb(input int mc);
    return SLOT_W * mc + LGC_W + CE_CHILD_W;
  endfunction

endpackage

// File: rtl/collective_instr_gen_tables.sv
// Runtime-programmable rank table and communicator table.
// One synchronous write port shared by both, combinational read ports.
module coll_tables
  import collective_pkg::*;
#(
  parameter int lg_numprocs    = 3,
  parameter int CommTableSize  = 4,
  parameter int CommTableWidth = 43,
  parameter int CtAddrW        = (CommTableSize > 1) ? $clog2(CommTableSize) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      we,
  input  logic                      sel,
  input  logic [7:0]                addr,
  input  logic [CommTableWidth-1:0] wdata,
  input  logic [lg_numprocs-1:0]    rank_raddr,
  output logic [RANK_W-1:0]         rank_rdata,
  input  logic [CtAddrW-1:0]        comm_raddr,
  output logic [CommTableWidth-1:0] comm_rdata
);

  localparam int NUM_PROCS = 1 << lg_numprocs;
  localparam logic [8:0] CT_LIMIT = 9'(CommTableSize);

  logic [RANK_W-1:0]         rank_tbl [NUM_PROCS];
  logic [CommTableWidth-1:0] comm_tbl [CommTableSize];

  // Table storage: cleared on reset, written whenever the strobe is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PROCS; i++) rank_tbl[i] <= '0;
      for (int i = 0; i < CommTableSize; i++) comm_tbl[i] <= '0;
    end else if (we) begin
      if (!sel) begin
        rank_tbl[addr[lg_numprocs-1:0]] <= wdata[RANK_W-1:0];
      end else if ({1'b0, addr} < CT_LIMIT) begin
        comm_tbl[CtAddrW'(addr)] <= wdata;
      end
    end
  end

  assign rank_rdata = rank_tbl[rank_raddr];
  assign comm_rdata = comm_tbl[comm_raddr];

endmodule

// File: rtl/collective_instr_gen.sv
// Collective instruction generator: turns one collective instruction
// flit into 1..MaxChildren routed flits using the communicator and
// rank tables.
//
// state  | meaning
// IDLE   | ready for an instruction; bad context pulses err_ctx
// LOOKUP | snapshot comm entry, work out flit count and start slot
// SEND   | present flits one at a time, advance on out_ready
module collective_instr_gen
  import collective_pkg::*;
#(
  parameter int         lg_numprocs    = 3,
  parameter int         MaxChildren    = 3,
  parameter int         CommTableSize  = 4,
  parameter int         rank           = 0,
  parameter int         root           = 0,
  parameter logic [2:0] rank_z         = 3'd0,
  parameter logic [2:0] rank_y         = 3'd0,
  parameter logic [2:0] rank_x         = 3'd0,
  parameter int         FlitWidth      = 73,
  parameter int         ChildrenWidth  = 3,
  parameter int         CommTableWidth = 9 * MaxChildren + 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [FlitWidth-1:0]              packetIn,
  output logic                              in_ready,
  output logic [FlitWidth+ChildrenWidth-1:0] packetOut,
  input  logic                              out_ready,
  input  logic                              tbl_we,
  input  logic                              tbl_sel,
  input  logic [7:0]                        tbl_addr,
  input  logic [CommTableWidth-1:0]         tbl_wdata,
  output logic                              err_ctx
);

  localparam int NUM_PROCS = 1 << lg_numprocs;
  localparam int CT_AW     = (CommTableSize > 1) ? $clog2(CommTableSize) : 1;
  localparam int CNT_W     = $clog2(MaxChildren + 1);
  localparam int SI_W      = (MaxChildren > 1) ? $clog2(MaxChildren) : 1;
  localparam int LGC_LSB   = lgc_lsb(MaxChildren);
  localparam int CH_LSB    = ce_child_lsb(MaxChildren);
  localparam int LR_LSB    = local_rank_lsb(MaxChildren);
  localparam int SLOTS_W   = SLOT_W * MaxChildren;
  localparam int PO_W      = FlitWidth + ChildrenWidth;
  localparam logic [8:0] CT_LIMIT = 9'(CommTableSize);
  localparam bit IS_ROOT   = (rank == root);
  localparam bit IS_LAST   = (rank == NUM_PROCS - 1);

  state_t                   state, state_nxt;
  logic [DST_LSB-1:0]       flit_q, flit_nxt;
  logic [SLOTS_W-1:0]       slots_q, slots_nxt;
  logic [ChildrenWidth-1:0] children_q, children_nxt;
  logic [CNT_W-1:0]         num_out_q, num_out_nxt;
  logic [CNT_W-1:0]         cnt_q, cnt_nxt, sel_cnt;
  logic [SI_W-1:0]          start_q, start_nxt, start_calc, slot_idx;
  logic                     use_own_q, use_own_nxt;
  logic                     use_root_q, use_root_nxt;
  logic [PO_W-1:0]          pkt_q, pkt_nxt, next_flit;
  logic                     err_q, err_nxt;

  logic [CT_AW-1:0]          comm_raddr;
  logic [CommTableWidth-1:0] comm_rdata;
  logic [lg_numprocs-1:0]    rank_raddr;
  logic [RANK_W-1:0]         rank_rdata;

  logic [SLOT_W-1:0] slots [MaxChildren];
  logic [SLOT_W-1:0] slot_sel;
  logic [DST_W-1:0]  dst;
  logic [7:0]        idx_full;
  logic [4:0]        raw_num;
  logic [CNT_W-1:0]  num_calc;
  alg_t              alg;
  logic              unused_ok;

  coll_tables #(
    .lg_numprocs   (lg_numprocs),
    .CommTableSize (CommTableSize),
    .CommTableWidth(CommTableWidth),
    .CtAddrW       (CT_AW)
  ) u_tables (
    .clk       (clk),
    .rst       (rst),
    .we        (tbl_we),
    .sel       (tbl_sel),
    .addr      (tbl_addr),
    .wdata     (tbl_wdata),
    .rank_raddr(rank_raddr),
    .rank_rdata(rank_rdata),
    .comm_raddr(comm_raddr),
    .comm_rdata(comm_rdata)
  );

  assign alg        = alg_t'(flit_q[ALG_LSB +: ALG_W]);
  assign comm_raddr = CT_AW'(flit_q[CTX_LSB +: CTX_W]);
  assign unused_ok  = ^{packetIn[FlitWidth-2:DST_LSB], comm_rdata[LR_LSB +: LOCAL_RANK_W],
                        slot_sel[SLOT_W-1:lg_numprocs]};

  // Unpack the snapshotted neighbour slots for indexed access.
  always_comb begin
    for (int i = 0; i < MaxChildren; i++) slots[i] = slots_q[SLOT_W*i +: SLOT_W];
  end

  // Build the flit to present: the current one at the start of SEND, the
  // following one when the presented flit is being accepted. The rank
  // table is read at presentation time so later writes only reach later flits.
  always_comb begin
    sel_cnt    = pkt_q[VALID_BIT] ? cnt_q + CNT_W'(1) : cnt_q;
    idx_full   = 8'(start_q) + 8'(sel_cnt);
    slot_idx   = (idx_full < 8'(MaxChildren)) ? SI_W'(idx_full) : '0;
    slot_sel   = slots[slot_idx];
    rank_raddr = use_root_q ? lg_numprocs'(root) : slot_sel[lg_numprocs-1:0];
    dst        = use_own_q ? {rank_z, rank_y, rank_x} : rank_rdata;
    next_flit  = {children_q, 1'b1, dst, flit_q};
  end

  // Flit count and starting slot for the captured algorithm.
  always_comb begin
    raw_num    = '0;
    start_calc = '0;
    case (alg)
      ALG_UPTREE: begin
        raw_num    = 5'd1;
        start_calc = SI_W'(MaxChildren - 1);
      end
      ALG_BCAST:    raw_num = {2'b00, comm_rdata[CH_LSB +: CE_CHILD_W]};
      ALG_RING:     raw_num = 5'd1;
      ALG_DOUBLING: raw_num = {1'b0, comm_rdata[LGC_LSB +: LGC_W]};
      default:      raw_num = '0;
    endcase
    num_calc = (raw_num > 5'(MaxChildren)) ? CNT_W'(MaxChildren) : CNT_W'(raw_num);
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_nxt    = state;
    flit_nxt     = flit_q;
    slots_nxt    = slots_q;
    children_nxt = children_q;
    num_out_nxt  = num_out_q;
    start_nxt    = start_q;
    use_own_nxt  = use_own_q;
    use_root_nxt = use_root_q;
    cnt_nxt      = cnt_q;
    pkt_nxt      = pkt_q;
    err_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (packetIn[VALID_BIT]) begin
          flit_nxt = packetIn[DST_LSB-1:0];
          if ({1'b0, packetIn[CTX_LSB +: CTX_W]} < CT_LIMIT) state_nxt = LOOKUP;
          else err_nxt = 1'b1;
        end
      end
      LOOKUP: begin
        slots_nxt    = comm_rdata[SLOTS_W-1:0];
        children_nxt = comm_rdata[CH_LSB +: ChildrenWidth];
        num_out_nxt  = num_calc;
        start_nxt    = start_calc;
        use_own_nxt  = IS_ROOT && (alg == ALG_UPTREE);
        use_root_nxt = IS_LAST && (alg == ALG_RING);
        cnt_nxt      = '0;
        state_nxt    = (num_calc == '0) ? IDLE : SEND;
      end
      SEND: begin
        if (!pkt_q[VALID_BIT]) begin
          pkt_nxt = next_flit;
        end else if (out_ready) begin
          if (cnt_q == num_out_q - CNT_W'(1)) begin
            pkt_nxt[VALID_BIT] = 1'b0;
            state_nxt          = IDLE;
          end else begin
            cnt_nxt = cnt_q + CNT_W'(1);
            pkt_nxt = next_flit;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      flit_q     <= '0;
      slots_q    <= '0;
      children_q <= '0;
      num_out_q  <= '0;
      start_q    <= '0;
      use_own_q  <= 1'b0;
      use_root_q <= 1'b0;
      cnt_q      <= '0;
      pkt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      flit_q     <= flit_nxt;
      slots_q    <= slots_nxt;
      children_q <= children_nxt;
      num_out_q  <= num_out_nxt;
      start_q    <= start_nxt;
      use_own_q  <= use_own_nxt;
      use_root_q <= use_root_nxt;
      cnt_q      <= cnt_nxt;
      pkt_q      <= pkt_nxt;
      err_q      <= err_nxt;
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign packetOut = pkt_q;
  assign err_ctx   = err_q;

endmodule

// File: tb/tb_collective_instr_gen.sv
// Self-checking bench for collective_instr_gen (rank 3, root 0).
module tb_collective_instr_gen;

  logic        clk;
  logic        rst;
  logic [72:0] packetIn;
  logic        in_ready;
  logic [75:0] packetOut;
  logic        out_ready;
  logic        tbl_we;
  logic        tbl_sel;
  logic [7:0]  tbl_addr;
  logic [42:0] tbl_wdata;
  logic        err_ctx;

  int n_asrt = 0;
  int n_fail = 0;
  logic [75:0] sb [$];

  localparam logic [8:0] D110 = 9'o110;
  localparam logic [8:0] D101 = 9'o101;
  localparam logic [8:0] D011 = 9'o011;
  localparam logic [8:0] D111 = 9'o111;
  localparam logic [8:0] D000 = 9'o000;

  collective_instr_gen #(.rank(3), .root(0)) dut (
    .clk      (clk),
    .rst      (rst),
    .packetIn (packetIn),
    .in_ready (in_ready),
    .packetOut(packetOut),
    .out_ready(out_ready),
    .tbl_we   (tbl_we),
    .tbl_sel  (tbl_sel),
    .tbl_addr (tbl_addr),
    .tbl_wdata(tbl_wdata),
    .err_ctx  (err_ctx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_asrt++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [72:0] mk_in(input logic [1:0] alg, input logic [7:0] ctx,
                                        input logic [31:0] pl);
    return {1'b1, 9'h000, 9'h0A5, ctx, 8'h3C, alg, 4'h9, pl};
  endfunction

  function automatic logic [75:0] ex(input logic [2:0] ch, input logic [8:0] d,
                                     input logic [72:0] fl);
    return {ch, 1'b1, d, fl[62:0]};
  endfunction

  function automatic logic [42:0] ce(input logic [2:0] ch, input logic [3:0] lg,
                                     input logic [8:0] s2, input logic [8:0] s1,
                                     input logic [8:0] s0);
    return {9'd0, ch, lg, s2, s1, s0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic sel, input logic [7:0] addr, input logic [42:0] data);
    tbl_we    = 1'b1;
    tbl_sel   = sel;
    tbl_addr  = addr;
    tbl_wdata = data;
    step();
    tbl_we    = 1'b0;
  endtask

  task automatic send(input logic [72:0] fl);
    int t = 0;
    while (!in_ready && t < 20) begin
      step();
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 128'(in_ready), 128'(1));
    packetIn = fl;
    step();
    packetIn = '0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 40) begin
      step();
      t++;
    end
    check("drain", 128'(sb.size()), 128'(0));
    repeat (3) step();
  endtask

  // Scoreboard: every accepted output flit must match the next expectation.
  always @(negedge clk) begin
    if (!rst && packetOut[72] && out_ready) begin
      if (sb.size() == 0) check("unexpected_flit", 128'(packetOut), 128'(0));
      else check("flit", 128'(packetOut), 128'(sb.pop_front()));
    end
  end

  initial begin
    logic [72:0] fl;
    logic [75:0] e2;

    rst = 1'b1; packetIn = '0; out_ready = 1'b1;
    tbl_we = 1'b0; tbl_sel = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    step(); step();
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_packetOut", 128'(packetOut), 128'(0));
    check("rst_err_ctx", 128'(err_ctx), 128'(0));
    rst = 1'b0;
    #1;
    check("in_ready_after_rst", 128'(in_ready), 128'(1));

    wr(1'b1, 8'd0, ce(3'd3, 4'd3, 9'd1, 9'd2, 9'd4));
    wr(1'b0, 8'd1, {34'd0, D110});
    wr(1'b0, 8'd2, {34'd0, D101});
    wr(1'b0, 8'd4, {34'd0, D011});

    // Uptree: slot 2 -> rank 1; latency two edges after acceptance.
    fl = mk_in(2'd0, 8'd0, 32'hDEADBEEF);
    sb.push_back(ex(3'd3, D110, fl));
    send(fl);
    check("uptree_busy", 128'(in_ready), 128'(0));
    check("lat_n0", 128'(packetOut[72]), 128'(0));
    step();
    check("lat_n1", 128'(packetOut[72]), 128'(0));
    step();
    check("lat_n2", 128'(packetOut[72]), 128'(1));
    drain();
    check("uptree_ready_back", 128'(in_ready), 128'(1));

    // Broadcast with a two-cycle stall on the second flit.
    fl = mk_in(2'd1, 8'd0, 32'h1111_0001);
    e2 = ex(3'd3, D101, fl);
    sb.push_back(ex(3'd3, D011, fl));
    sb.push_back(e2);
    sb.push_back(ex(3'd3, D110, fl));
    send(fl);
    step(); step(); step();
    out_ready = 1'b0;
    check("stall_0", 128'(packetOut), 128'(e2));
    step();
    check("stall_1", 128'(packetOut), 128'(e2));
    step();
    check("stall_2", 128'(packetOut), 128'(e2));
    out_ready = 1'b1;
    drain();

    // Ring, with a rank-table address that must truncate to index 4.
    wr(1'b0, 8'h0C, {34'd0, D111});
    fl = mk_in(2'd2, 8'd0, 32'h2222_0002);
    sb.push_back(ex(3'd3, D111, fl));
    send(fl);
    drain();
    wr(1'b0, 8'd4, {34'd0, D011});

    // Recursive doubling with lg_commsize 7: clamped to three flits.
    wr(1'b1, 8'd1, ce(3'd3, 4'd7, 9'd1, 9'd2, 9'd4));
    fl = mk_in(2'd3, 8'd1, 32'h3333_0003);
    sb.push_back(ex(3'd3, D011, fl));
    sb.push_back(ex(3'd3, D101, fl));
    sb.push_back(ex(3'd3, D110, fl));
    send(fl);
    drain();

    // Rank-table write while the first broadcast flit is stalled.
    out_ready = 1'b0;
    fl = mk_in(2'd1, 8'd0, 32'h4444_0004);
    sb.push_back(ex(3'd3, D011, fl));
    sb.push_back(ex(3'd3, D101, fl));
    sb.push_back(ex(3'd3, D000, fl));
    send(fl);
    step(); step();
    check("ws_first", 128'(packetOut), 128'(ex(3'd3, D011, fl)));
    wr(1'b0, 8'd1, 43'd0);
    check("ws_first_hold", 128'(packetOut), 128'(ex(3'd3, D011, fl)));
    out_ready = 1'b1;
    drain();
    wr(1'b0, 8'd1, {34'd0, D110});

    // Leaf: zero children, no output.
    wr(1'b1, 8'd0, ce(3'd0, 4'd3, 9'd1, 9'd2, 9'd4));
    fl = mk_in(2'd1, 8'd0, 32'h5555_0005);
    send(fl);
    step(); step();
    check("leaf_ready", 128'(in_ready), 128'(1));
    check("leaf_noout", 128'(packetOut[72]), 128'(0));
    repeat (3) step();
    wr(1'b1, 8'd0, ce(3'd3, 4'd3, 9'd1, 9'd2, 9'd4));

    // Invalid context.
    fl = mk_in(2'd1, 8'd5, 32'h6666_0006);
    send(fl);
    check("err_pulse", 128'(err_ctx), 128'(1));
    check("err_idle", 128'(in_ready), 128'(1));
    step();
    check("err_end", 128'(err_ctx), 128'(0));
    check("err_noout", 128'(packetOut[72]), 128'(0));
    repeat (3) step();

    // Reset in the middle of a doubling burst.
    fl = mk_in(2'd3, 8'd0, 32'h7777_0007);
    sb.push_back(ex(3'd3, D011, fl));
    send(fl);
    step(); step(); step();
    check("rst_pre", 128'(packetOut), 128'(ex(3'd3, D101, fl)));
    rst = 1'b1;
    step();
    check("midrst_pkt", 128'(packetOut), 128'(0));
    check("midrst_in_ready", 128'(in_ready), 128'(0));
    check("midrst_sb", 128'(sb.size()), 128'(0));
    rst = 1'b0;
    repeat (4) step();
    check("no_stale", 128'(packetOut[72]), 128'(0));

    // Tables are empty after reset; out-of-range comm write is ignored.
    wr(1'b1, 8'd0, ce(3'd1, 4'd0, 9'd0, 9'd0, 9'd2));
    wr(1'b1, 8'd4, ce(3'd3, 4'd3, 9'd1, 9'd2, 9'd4));
    fl = mk_in(2'd1, 8'd0, 32'h8888_0008);
    sb.push_back(ex(3'd1, D000, fl));
    send(fl);
    drain();
    fl = mk_in(2'd1, 8'd1, 32'h9999_0009);
    send(fl);
    repeat (3) step();
    check("cleared_comm_leaf", 128'(packetOut[72]), 128'(0));
    check("cleared_ready", 128'(in_ready), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/collective_instr_gen.md
Name: collective_instr_gen

Overview:
- Successor to the single-destination reduce instruction stage.
- Accepts one collective-instruction flit, looks up the communicator and rank tables, and emits 1..MaxChildren routed flits. Each emitted flit carries the children count.
- Destination selection depends on algtype: uptree, broadcast fan-out, ring, or recursive doubling.
- Sits between the node's instruction injector and the router ingress. Tables are runtime-programmable instead of hard-coded.

Parameters:
- lg_numprocs, 3, log2 of the rank-table depth; num_procs = 1<<lg_numprocs.
- MaxChildren, 3, neighbour slots per communicator entry; must be >= lg_numprocs.
- CommTableSize, 4, number of communicator entries (contexts).
- rank, 0, this node's rank.
- root, 0, root rank.
- rank_z / rank_y / rank_x, 0 each, 3-bit own coordinates.
- FlitWidth, 73, input flit width. Field positions follow the existing flit layout: payload 31-0, op 35-32, algtype 37-36, tag 45-38, contextId 53-46, src 62-54, dst 71-63, valid 72.
- ChildrenWidth, 3, width of the children field prepended at bits 75-73.
- CommTableWidth, 9*MaxChildren+16, entry layout: local_rank(9) | children(3) | lg_commsize(4) | slot[MaxChildren-1]..slot[0], 9 bits each. Default is 43.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset.
- packetIn, in, FlitWidth, instruction flit; bit 72 is the valid bit.
- in_ready, out, 1, block can accept packetIn.
- packetOut, out, FlitWidth+ChildrenWidth, generated flit; bit 72 is the valid bit.
- out_ready, in, 1, router accepts packetOut.
- tbl_we, in, 1, table write strobe.
- tbl_sel, in, 1, selects table: 0 = rank table, 1 = comm table.
- tbl_addr, in, 8, table index.
- tbl_wdata, in, CommTableWidth, write data; rank-table writes use bits [8:0].
- err_ctx, out, 1, one-cycle pulse when an instruction is dropped for an invalid context.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. Reset takes priority over every other event, including an in-flight burst.
- Reset values:
  - state = IDLE.
  - packetOut = 0, including the valid bit.
  - err_ctx = 0.
  - Both tables cleared to 0.
  - in_ready = 0 while rst is high; it reads 1 on the first cycle after rst falls.
- Table writes:
  - Allowed in any state; performed on the clock edge when tbl_we is high.
  - A rank-table index wider than lg_numprocs is truncated to lg_numprocs bits.
  - A comm-table write with tbl_addr >= CommTableSize is ignored.
- FSM states: IDLE, LOOKUP, SEND.
- IDLE:
  - in_ready = 1.
  - When packetIn[72] is high, the flit is captured. If contextId < CommTableSize, go to LOOKUP; otherwise pulse err_ctx and stay in IDLE.
- LOOKUP (1 cycle):
  - Snapshot the comm entry for the captured context.
  - Compute num_out and the start slot from algtype:
    - 00 uptree: num_out = 1, slot MaxChildren-1. If rank == root, dst = own coordinates.
    - 01 broadcast: num_out = entry children, slots 0..children-1 in ascending order.
    - 10 ring: num_out = 1, slot 0. If rank == num_procs-1, dst = rank_table[root].
    - 11 recursive doubling: num_out = lg_commsize, slots 0..lg_commsize-1.
  - num_out is clamped to MaxChildren.
  - If num_out == 0 (leaf), return to IDLE and emit nothing. Otherwise go to SEND with send_cnt = 0.
- SEND:
  - packetOut is driven from registers:
    - payload, op, algtype, tag, contextId and src are copied from the input flit.
    - dst = rank_table[slot[start+send_cnt]].
    - children field = entry children.
    - valid bit = 1.
  - On a cycle with valid && out_ready: send_cnt increments. When the last flit is accepted, go to IDLE and drop the valid bit in the same cycle.
  - While out_ready is low, packetOut holds stable.
  - Rank-table writes made during SEND affect only flits not yet presented.
- Latency: a flit accepted at edge N presents its first output flit after edge N+2. Back-to-back output flits are issued at one per cycle when out_ready is held high.
- Throughput: one instruction at a time. in_ready stays low in LOOKUP and SEND.

Decomposition:
- Shared package collective_pkg holds:
  - flit field position/width constants;
  - algtype encodings ALG_UPTREE = 0, ALG_BCAST = 1, ALG_RING = 2, ALG_DOUBLING = 3;
  - comm-entry field offsets.
- One sub-module, coll_tables: rank table and comm table, with a synchronous write port and combinational read ports. The FSM, slot mux and output register stay in the top level.

Test Plan:
- Table setup for the scenarios:
  - comm[0]: children = 3, lg_commsize = 3, slot0 = 4, slot1 = 2, slot2 = 1.
  - rank table: 1 -> {1,1,0}, 2 -> {1,0,1}, 4 -> {0,1,1}.
- Uptree, with rank = 3, root = 0: input algtype 00, ctx 0, payload 0xDEADBEEF. Expect one flit 2 cycles later with dst z,y,x = 1,1,0, children = 3, payload and src unchanged. in_ready returns high after acceptance.
- Broadcast, algtype 01: expect flits with dst {0,1,1}, {1,0,1}, {1,1,0} in that order. Hold out_ready low for 2 cycles on flit 2: flit 2 stays stable with no duplicate and no skip.
- Leaf and bad context:
  - Set comm[0] children = 0 and issue a broadcast: no output flit; in_ready is high again 2 cycles later.
  - Issue ctx = 5: err_ctx pulses for 1 cycle, no output.
- Reset mid-burst: assert rst during flit 2 of a doubling burst. Next cycle: packetOut = 0, tables are zero, and no stale flit appears after rst falls.
- Write during SEND: rewrite rank[1] to {0,0,0} while flit 1 of a broadcast is stalled. The third flit shows dst {0,0,0}; the first flit is unchanged.
